conv_enc: RTL
=============

# conv_enc

Rate-1/2, constraint-length-3 convolutional encoder (generators 7/5 octal): the transmit-side counterpart of the Viterbi decoder's control and datapath. It accepts a frame of serial data bits over a valid/ready handshake and emits one 2-bit coded symbol per bit through a single-entry output register. It then appends zero tail bits, so the decoder's traceback starts from state 0. It sits between the bit source and the channel/decoder input in the loopback test path.

## Interface
- K, 3, constraint length; shift register holds K-1 bits.
- G0, 3'b111, generator for out_sym[1]; bit K-1 is the current input, bit 0 is the oldest.
- G1, 3'b101, generator for out_sym[0].
- LEN_W, 8, width of frame_len and the bit counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- en  in  1  frame start; sampled only in IDLE.
- frame_len  in  LEN_W  number of data bits; sampled together with en.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- in_bit  in  1  data bit.
- out_valid  out  1  out_sym holds a valid symbol.
- out_ready  in  1  downstream consumes the symbol.
- out_sym  out  2  coded symbol; [1] = G0 parity, [0] = G1 parity.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last symbol of a frame is consumed.

## Operation
- States: IDLE, DATA, TAIL, FIN.
- IDLE:
  - When en=1 and frame_len≠0: latch frame_len, clear bit counter and shift register, go to DATA.
  - en with frame_len=0 is ignored; the block stays in IDLE.
- DATA:
  - in_ready = (!out_valid || out_ready).
  - On in_valid && in_ready:
    - window w = {in_bit, sr};
    - out_sym ← {^(w&G0), ^(w&G1)};
    - sr shifts in in_bit;
    - counter increments.
  - After frame_len bits have been accepted, go to TAIL.
- TAIL:
  - in_ready=0.
  - Inject K-1 zero bits, one per output slot, using the same slot rule as DATA. Each slot is taken when !out_valid || out_ready.
  - After the last tail bit is injected, go to FIN.
- FIN:
  - Wait until the final symbol is consumed (out_valid && out_ready).
  - Pulse done and go to IDLE.
- Output buffer:
  - out_valid is set when a symbol is loaded.
  - out_valid is cleared on out_ready unless a new symbol loads in the same cycle.
  - out_sym stays stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - A consume and a load in the same cycle keep out_valid=1 and present the new symbol.
  - en while busy is ignored.
- Counter: LEN_W bits. frame_len = 2^LEN_W−1 is legal; the counter does not wrap within a frame.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_sym=2'b00, busy=0, done=0;
  - state=IDLE, sr=0, counter=0.
- en accepted at edge t → busy=1 and in_ready=1 after edge t (first data can be accepted at edge t+1).
- Latency: bit accepted at edge t → its symbol is valid after edge t; one cycle, register to register.
- Throughput: one symbol per cycle with out_ready held high. A frame of N bits occupies N+K-1 output cycles plus one FIN cycle.
- done is high for exactly the cycle following the final consume; busy falls in that same cycle.
- rst asserted mid-frame aborts immediately. No partial symbol or done is produced afterwards.

## Configuration
- CONV_ENC_TAIL_EN defined: K-1 zero tail bits are appended (zero-terminated trellis), as described above.
- Not defined: the TAIL state is removed and DATA goes directly to FIN. A frame produces exactly N symbols. sr is still cleared at every frame start.

## Structure
- Shared package conv_pkg holds:
  - K, G0 and G1 defaults, shared with the decoder's branch-metric unit;
  - the state encoding enum (IDLE/DATA/TAIL/FIN);
  - a parity function.
- One sub-module, conv_sym_gen: purely combinational (window → 2-bit symbol). It is reused by the decoder testbench's reference model.
- Top level holds the FSM, counter, shift register and output register.

## Test plan
- Reset then en with frame_len=4, bits 1,0,1,1, out_ready=1 → out_sym sequence 11,10,00,01,01,11, then done pulse, busy=0.
- Same frame with CONV_ENC_TAIL_EN undefined → 11,10,00,01, then done.
- Same frame with out_ready low for 3 cycles after the second symbol → out_sym holds 10, in_ready=0, no symbol lost or duplicated.
- en with frame_len=0 → busy stays 0, no out_valid. en pulsed mid-frame → ignored, frame output unchanged.
- rst pulsed low after the second accepted bit → all outputs return to their reset values. A following frame of 1,1 gives 11,01,01,11.
- Back-to-back frames, en reasserted in the cycle after done → second frame encodes from sr=0 (first symbol of input 1 is 11).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional code (generators 7/5 octal).
// Used by the encoder and by the decoder's branch-metric unit.
package conv_pkg;

    // Code defaults shared with the decoder side.
    localparam int unsigned     DefK    = 3;
    localparam logic [DefK-1:0] DefG0   = 3'b111;
    localparam logic [DefK-1:0] DefG1   = 3'b101;
    localparam int unsigned     DefLenW = 8;

    // Encoder control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StTail = 2'd2,
        StFin  = 2'd3
    } enc_state_e;

    // Even/odd parity of a tapped window; narrower vectors are zero-extended by the caller.
    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_sym_gen.sv
// Combinational symbol generator: K-bit window (bit K-1 = newest) -> 2-bit coded symbol.
// sym[1] is the G0 parity, sym[0] the G1 parity.
module conv_sym_gen
    import conv_pkg::*;
#(
    parameter int unsigned    K  = DefK,
    parameter logic [K-1:0]   G0 = DefG0,
    parameter logic [K-1:0]   G1 = DefG1
) (
    input  logic [K-1:0] window,
    output logic [1:0]   sym
);

    assign sym[1] = parity(32'(window & G0));
    assign sym[0] = parity(32'(window & G1));

endmodule

// File: rtl/conv_enc.sv
// Rate-1/2 convolutional encoder with valid/ready input and a single-entry output register.
// Build option: define CONV_ENC_TAIL_EN to append K-1 zero tail bits after each frame
// (zero-terminated trellis); without it a frame of N bits yields exactly N symbols.
module conv_enc
    import conv_pkg::*;
#(
    parameter int unsigned  K     = DefK,
    parameter logic [K-1:0] G0    = DefG0,
    parameter logic [K-1:0] G1    = DefG1,
    parameter int unsigned  LEN_W = DefLenW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sym,
    output logic             busy,
    output logic             done
);

    enc_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [K-2:0]     sr_q, sr_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_sym_q, out_sym_d;
    logic             done_q, done_d;

    logic             slot_free;
    logic             load;
    logic             enc_bit;
    logic [K-1:0]     window;
    logic [1:0]       sym;

    // Output slot can take a new symbol when empty or being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;

    // Only DATA feeds real bits; tail slots (and idle) encode zeros.
    assign enc_bit = (state_q == StData) ? in_bit : 1'b0;
    assign window  = {enc_bit, sr_q};

    conv_sym_gen #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_sym_gen (
        .window (window),
        .sym    (sym)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        load        = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (en && (frame_len != '0)) begin
                    len_d   = frame_len;
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = StData;
                end
            end
            StData: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load  = 1'b1;
                    cnt_d = cnt_q + LEN_W'(1);
                    // Compare before incrementing so a full-width frame never wraps.
                    if (cnt_q == len_q - LEN_W'(1)) begin
`ifdef CONV_ENC_TAIL_EN
                        cnt_d   = '0;
                        state_d = StTail;
`else
                        state_d = StFin;
`endif
                    end
                end
            end
`ifdef CONV_ENC_TAIL_EN
            StTail: begin
                if (slot_free) begin
                    load  = 1'b1;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == LEN_W'(K - 2)) begin
                        state_d = StFin;
                    end
                end
            end
`endif
            StFin: begin
                if (out_valid_q && out_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A load wins over a same-cycle drain, so out_valid stays high with the new symbol.
        if (load) begin
            out_valid_d = 1'b1;
            out_sym_d   = sym;
            sr_d        = window[K-1:1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, shift register, output register and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule
